tl_uh_sram_responder: RTL and testbench
=======================================

# tl_uh_sram_responder

TileLink Uncached Heavyweight (TL-UH) slave that terminates the 32-bit A/D channel pair driven by the data-cache master, backed by an on-chip byte-writable synchronous SRAM. It accepts Get, PutFullData and PutPartialData, including multi-beat bursts for cache-line fills and write-backs. It returns AccessAckData or AccessAck on D with backpressure support. It sits on the memory-side end of the memory system's TileLink link as boot/scratch RAM and as the reference slave for bus verification.

## Interface
- DEPTH_WORDS, 4096: SRAM depth in 32-bit words; must be a power of two.
- MAX_SIZE, 6: largest accepted a_size (log2 bytes); 6 = 64 B = 16 beats.
- cpu_clk_i  in  1  clock; all logic on the rising edge.
- cpu_rst_ni  in  1  reset, synchronous, active-low.
- mem_a_opcode  in  3  0 PutFullData, 1 PutPartialData, 4 Get; others unsupported.
- mem_a_param  in  3  ignored.
- mem_a_size  in  4  log2 of transfer bytes.
- mem_a_address  in  32  byte address.
- mem_a_mask  in  4  byte lanes.
- mem_a_data  in  32  write data.
- mem_a_corrupt  in  1  beat poisoned; the beat is not written.
- mem_a_valid  in  1  A beat valid.
- mem_a_ready  out  1  A beat accepted when valid&ready.
- mem_d_opcode  out  3  0 AccessAck, 1 AccessAckData.
- mem_d_param  out  2  always 0.
- mem_d_size  out  4  echo of the request a_size.
- mem_d_denied  out  1  request rejected.
- mem_d_data  out  32  read data.
- mem_d_corrupt  out  1  equals denied on AccessAckData; 0 on AccessAck.
- mem_d_valid  out  1  D beat valid.
- mem_d_ready  in  1  D beat consumed when valid&ready.

## Operation
- Beats per request: N = (size<=2) ? 1 : 2^(size-2). Beat k uses word address (addr[31:2] + k) modulo DEPTH_WORDS.
- States:
  - IDLE: a_ready=1. On an A fire, latch opcode, size, address and N. Get goes to RD. Put writes beat 0 (lanes = mask, skipped if corrupt or denied). Put with N=1 goes to ACK; otherwise it goes to WR.
  - WR: a_ready=1. Each fire writes the next beat. The last beat goes to ACK. Opcode, size and address on non-first beats are ignored.
  - ACK: d_valid=1, d_opcode=AccessAck. On d_ready, return to IDLE.
  - RD: issue SRAM reads and stream N AccessAckData beats. On the last beat fire, return to IDLE.
- PutFullData with mask not all lanes for size>=2 is written using the mask as given; it is not flagged.
- Only one transaction is outstanding. a_ready=0 in RD and ACK.

## Timing
- Reset values: a_ready=0 while cpu_rst_ni=0, then 1 (IDLE). d_valid, d_opcode, d_size, d_denied, d_data and d_corrupt are all 0. SRAM contents are not reset.
- Get: A fire in cycle 0, SRAM read in cycle 1, d_valid with beat 0 in cycle 2. With d_ready held high, one beat per cycle, so the last beat arrives in cycle N+1.
- D backpressure: d_data, d_valid and d_opcode are held stable until d_ready. The SRAM read address re-reads the held beat, and there is no data loss.
- Put: the last beat fires in cycle t, and AccessAck is valid in cycle t+1.
- Reset asserted mid-burst: the FSM goes to IDLE next edge. Partial Put writes already done persist.
- An A beat arriving during RD or ACK is stalled, never dropped.

## Configuration
- TL_RESP_ERRCHK_EN defined:
  - denied=1 when any of these holds: unsupported opcode; size>MAX_SIZE; address not aligned to 2^size; address >= DEPTH_WORDS*4.
  - A denied Get returns N beats with data 0, denied=1, corrupt=1. Unsupported opcodes and oversize requests are answered as a single beat.
  - A denied Put consumes all beats, writes nothing, and acks with denied=1.
- TL_RESP_ERRCHK_EN undefined:
  - No checks. d_denied and d_corrupt are tied to 0.
  - Address bits above the index wrap, and low bits below 2^size are ignored.
  - Unsupported opcodes get a single-beat AccessAck with no write.

## Structure
- Package tl_pkg:
  - A/D opcode enums (TL_PUT_FULL, TL_PUT_PARTIAL, TL_GET, TL_ACCESS_ACK, TL_ACCESS_ACK_DATA).
  - Responder state enum (IDLE, WR, RD, ACK).
  - Beat-count helper function.
- Sub-module tl_sram_bank: single-port synchronous RAM, DEPTH_WORDS x 32, with 4 byte write enables and 1-cycle read latency.

## Test plan
- Single-word write then read: Put size 2 to 0x10, data 0xDEADBEEF, mask 0xF -> AccessAck, denied 0. Get size 2 at 0x10 -> AccessAckData 0xDEADBEEF in cycle 2.
- Partial write: PutPartial at 0x10 with mask 0x3, data 0x00001234 -> a subsequent Get returns 0xDEAD1234.
- Burst: a 32 B PutFull at 0x40 with data i+1 for 8 beats, then a Get of size 5 at 0x40 -> 8 beats 1..8 in cycles 2..9.
- Backpressure: the same Get with d_ready toggled 1,0,0,1... -> each beat is held stable while stalled and the 8 beats arrive in order; a_ready stays 0 until the last beat fires.
- Errors (ERRCHK_EN): Get size 2 at 0x12 -> denied=1, corrupt=1, data 0. Get at DEPTH_WORDS*4 -> denied=1. opcode 2 -> single AccessAck denied=1, memory unchanged.
- Reset mid-burst: assert cpu_rst_ni=0 after beat 3 of an 8-beat Get -> next cycle d_valid=0. After release, a_ready=1 and a fresh Get completes normally.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink opcodes, responder FSM states and the
// beat-count helper shared by the TL-UH SRAM responder.
package tl_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    ACK
  } tl_state_e;

  // Index of the last beat of a request (beats - 1).
  // Sizes above max_size are clamped so counters stay small.
  function automatic int unsigned tl_last_beat(
    input logic [3:0]  size,
    input int unsigned max_size
  );
    int unsigned s;
    s = {28'd0, size};
    if (s > max_size) s = max_size;
    return (s <= 2) ? 0 : (32'd1 << (s - 2)) - 1;
  endfunction

endpackage

// File: rtl/tl_sram_bank.sv
// tl_sram_bank: single-port DEPTH_WORDS x 32 synchronous RAM,
// 4 byte write enables, registered read data (1-cycle latency).
module tl_sram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_uh_sram_responder.sv
// tl_uh_sram_responder: TL-UH slave on a 32-bit A/D pair backed by
// tl_sram_bank. Get / PutFull / PutPartial with bursts up to 2^MAX_SIZE B.
// Ports: cpu_clk_i, cpu_rst_ni (sync, active-low), mem_a_* (request in),
// mem_d_* (response out). Macro TL_RESP_ERRCHK_EN enables denied checks.
module tl_uh_sram_responder
  import tl_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int MAX_SIZE    = 6
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic [2:0]  mem_a_opcode,
  input  logic [2:0]  mem_a_param,
  input  logic [3:0]  mem_a_size,
  input  logic [31:0] mem_a_address,
  input  logic [3:0]  mem_a_mask,
  input  logic [31:0] mem_a_data,
  input  logic        mem_a_corrupt,
  input  logic        mem_a_valid,
  output logic        mem_a_ready,
  output logic [2:0]  mem_d_opcode,
  output logic [1:0]  mem_d_param,
  output logic [3:0]  mem_d_size,
  output logic        mem_d_denied,
  output logic [31:0] mem_d_data,
  output logic        mem_d_corrupt,
  output logic        mem_d_valid,
  input  logic        mem_d_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = (MAX_SIZE > 2) ? MAX_SIZE - 2 : 1;

  tl_state_e     state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    size_q, size_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          den_q, den_d;
  logic          vld_q, vld_d;

  logic          a_fire, d_fire;
  logic          req_get, req_put, req_ok, req_den;
  logic [LW-1:0] req_last, rd_idx;
  logic [AW-1:0] req_base, sram_addr;
  logic [3:0]    sram_we;
  logic [31:0]   sram_rdata;
  logic          rd_beat;
  logic          unused_ok;

  assign unused_ok = ^{mem_a_param, mem_a_address};

  assign req_get = (mem_a_opcode == TL_GET);
  assign req_put = (mem_a_opcode == TL_PUT_FULL) |
                   (mem_a_opcode == TL_PUT_PARTIAL);
  assign req_ok  = req_get | req_put;

`ifdef TL_RESP_ERRCHK_EN
  logic big, misal, oob;
  assign big     = mem_a_size > 4'(MAX_SIZE);
  assign misal   = |(mem_a_address & ((32'd1 << mem_a_size) - 32'd1));
  assign oob     = |mem_a_address[31:AW+2];
  assign req_den = !req_ok | big | misal | oob;
`else
  assign req_den = 1'b0;
`endif

  // Unsupported (and, when checked, oversize) requests are one beat.
  always_comb begin
    req_last = LW'(tl_last_beat(mem_a_size, MAX_SIZE));
    if (!req_ok) req_last = '0;
`ifdef TL_RESP_ERRCHK_EN
    if (big) req_last = '0;
`endif
  end

  // Base word aligned to the transfer size; index wraps at DEPTH.
  assign req_base = mem_a_address[AW+1:2] & ~AW'(req_last);

  assign mem_a_ready = cpu_rst_ni & ((state_q == IDLE) | (state_q == WR));
  assign a_fire      = mem_a_valid & mem_a_ready;
  assign d_fire      = mem_d_valid & mem_d_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    base_d    = base_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    den_d     = den_q;
    vld_d     = vld_q;
    sram_we   = '0;
    rd_idx    = cnt_q;
    sram_addr = base_q + AW'(cnt_q);
    unique case (state_q)
      IDLE: begin
        sram_addr = req_base;
        if (a_fire) begin
          op_d   = mem_a_opcode;
          size_d = mem_a_size;
          base_d = req_base;
          last_d = req_last;
          den_d  = req_den;
          cnt_d  = '0;
          vld_d  = 1'b0;
          if (req_get) begin
            state_d = RD;
          end else begin
            if (req_put & !req_den & !mem_a_corrupt) sram_we = mem_a_mask;
            if (req_put && req_last != '0) begin
              state_d = WR;
              cnt_d   = LW'(1);
            end else begin
              state_d = ACK;
            end
          end
        end
      end
      WR: begin
        if (a_fire) begin
          if (!den_q & !mem_a_corrupt) sram_we = mem_a_mask;
          if (cnt_q == last_q) state_d = ACK;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      RD: begin
        // Fetch the next beat on a fire, else re-read the held one.
        if (d_fire) rd_idx = cnt_q + 1'b1;
        sram_addr = base_q + AW'(rd_idx);
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (d_fire) begin
          if (cnt_q == last_q) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = rd_idx;
          end
        end
      end
      ACK: begin
        if (mem_d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      size_q  <= '0;
      base_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      den_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      base_q  <= base_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
      vld_q   <= vld_d;
    end
  end

  tl_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk_i   (cpu_clk_i),
    .addr_i  (sram_addr),
    .we_i    (sram_we),
    .wdata_i (mem_a_data),
    .rdata_o (sram_rdata)
  );

  assign rd_beat       = (state_q == RD) & vld_q;
  assign mem_d_valid   = rd_beat | (state_q == ACK);
  assign mem_d_opcode  = rd_beat ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  assign mem_d_param   = 2'd0;
  assign mem_d_size    = mem_d_valid ? size_q : 4'd0;
  assign mem_d_denied  = mem_d_valid & den_q;
  assign mem_d_corrupt = rd_beat & den_q;
  assign mem_d_data    = (rd_beat & !den_q) ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_tl_uh_sram_responder.sv
// tb_tl_uh_sram_responder: directed scoreboard bench for the
// TL-UH SRAM responder (default or TL_RESP_ERRCHK_EN build).
module tb_tl_uh_sram_responder;

  localparam int DEPTH = 4096;
  localparam int MAXS  = 6;
`ifdef TL_RESP_ERRCHK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic        den;
    logic [31:0] data;
    logic        cor;
    logic [3:0]  size;
  } exp_t;

  logic        cpu_clk_i = 1'b0;
  logic        cpu_rst_ni = 1'b0;
  logic [2:0]  mem_a_opcode = '0;
  logic [2:0]  mem_a_param = '0;
  logic [3:0]  mem_a_size = '0;
  logic [31:0] mem_a_address = '0;
  logic [3:0]  mem_a_mask = '0;
  logic [31:0] mem_a_data = '0;
  logic        mem_a_corrupt = 1'b0;
  logic        mem_a_valid = 1'b0;
  logic        mem_a_ready;
  logic [2:0]  mem_d_opcode;
  logic [1:0]  mem_d_param;
  logic [3:0]  mem_d_size;
  logic        mem_d_denied;
  logic [31:0] mem_d_data;
  logic        mem_d_corrupt;
  logic        mem_d_valid;
  logic        mem_d_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fire = 0;
  exp_t sb[$];
  logic [31:0] model [DEPTH];

  tl_uh_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .MAX_SIZE    (MAXS)
  ) dut (
    .cpu_clk_i     (cpu_clk_i),
    .cpu_rst_ni    (cpu_rst_ni),
    .mem_a_opcode  (mem_a_opcode),
    .mem_a_param   (mem_a_param),
    .mem_a_size    (mem_a_size),
    .mem_a_address (mem_a_address),
    .mem_a_mask    (mem_a_mask),
    .mem_a_data    (mem_a_data),
    .mem_a_corrupt (mem_a_corrupt),
    .mem_a_valid   (mem_a_valid),
    .mem_a_ready   (mem_a_ready),
    .mem_d_opcode  (mem_d_opcode),
    .mem_d_param   (mem_d_param),
    .mem_d_size    (mem_d_size),
    .mem_d_denied  (mem_d_denied),
    .mem_d_data    (mem_d_data),
    .mem_d_corrupt (mem_d_corrupt),
    .mem_d_valid   (mem_d_valid),
    .mem_d_ready   (mem_d_ready)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;
  always @(posedge cpu_clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbeats(input logic [3:0] s);
    return (s <= 2) ? 1 : (1 << (s - 2));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a, input int nb,
                                       input int k);
    int unsigned b;
    b = (a >> 2) & ~(32'(nb) - 1);
    return (b + 32'(k)) % DEPTH;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat fired.
  task automatic send_beat(input logic [2:0] op, input logic [3:0] size,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic cor);
    int t = 0;
    mem_a_opcode = op;
    mem_a_size = size;
    mem_a_address = addr;
    mem_a_mask = mask;
    mem_a_data = data;
    mem_a_corrupt = cor;
    mem_a_valid = 1'b1;
    @(negedge cpu_clk_i);
    while (!mem_a_ready && t < 100) begin
      @(negedge cpu_clk_i);
      t++;
    end
    chk("a_accept", {31'd0, mem_a_ready}, 32'd1);
    last_fire = cyc;
    @(posedge cpu_clk_i);
    #1;
    mem_a_valid = 1'b0;
    mem_a_corrupt = 1'b0;
  endtask

  task automatic collect(input int nb, input int lat, input bit bp);
    int got = 0;
    int t = 0;
    int idx = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    exp_t e;
    while (got < nb && t < 300) begin
      mem_d_ready = bp ? ((idx % 4) == 0 || (idx % 4) == 3) : 1'b1;
      idx++;
      @(negedge cpu_clk_i);
      if (stalled) begin
        chk("hold_valid", {31'd0, mem_d_valid}, 32'd1);
        chk("hold_data", mem_d_data, held);
      end
      if (mem_d_valid) begin
        chk("a_stall", {31'd0, mem_a_ready}, 32'd0);
        if (mem_d_ready) begin
          e = sb.pop_front();
          chk("d_op", {29'd0, mem_d_opcode}, {29'd0, e.op});
          chk("d_den", {31'd0, mem_d_denied}, {31'd0, e.den});
          chk("d_cor", {31'd0, mem_d_corrupt}, {31'd0, e.cor});
          chk("d_size", {28'd0, mem_d_size}, {28'd0, e.size});
          chk("d_data", mem_d_data, e.data);
          if (lat >= 0) chk("d_lat", 32'(cyc - last_fire), 32'(lat + got));
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = mem_d_data;
        end
      end
      @(posedge cpu_clk_i);
      #1;
      t++;
    end
    chk("d_timeout", 32'(got), 32'(nb));
    mem_d_ready = 1'b0;
  endtask

  task automatic get_req(input logic [3:0] size, input logic [31:0] addr,
                         input bit den, input int nb, input int lat,
                         input bit bp, input int take);
    exp_t e;
    for (int k = 0; k < nb; k++) begin
      e.op = 3'd1;
      e.den = den;
      e.data = den ? 32'd0 : model[widx(addr, nb, k)];
      e.cor = den;
      e.size = size;
      sb.push_back(e);
    end
    send_beat(3'd4, size, addr, 4'hF, 32'd0, 1'b0);
    collect(take, lat, bp);
  endtask

  task automatic put_req(input logic [2:0] op, input logic [3:0] size,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] dbase, input logic [31:0] dstep,
                         input logic [15:0] cmask, input bit den,
                         input int nb);
    exp_t e;
    logic [31:0] d;
    int unsigned w;
    e.op = 3'd0;
    e.den = den;
    e.data = 32'd0;
    e.cor = 1'b0;
    e.size = size;
    sb.push_back(e);
    for (int k = 0; k < nb; k++) begin
      d = dbase + 32'(k) * dstep;
      send_beat(op, size, addr, mask, d, cmask[k]);
      if (op <= 3'd1 && !den && !cmask[k]) begin
        w = widx(addr, nb, k);
        for (int b = 0; b < 4; b++)
          if (mask[b]) model[w][8*b +: 8] = d[8*b +: 8];
      end
    end
    collect(1, 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge cpu_clk_i);
    @(negedge cpu_clk_i);
    chk("rst_a_ready", {31'd0, mem_a_ready}, 32'd0);
    chk("rst_d_valid", {31'd0, mem_d_valid}, 32'd0);
    chk("rst_d_op", {29'd0, mem_d_opcode}, 32'd0);
    chk("rst_d_size", {28'd0, mem_d_size}, 32'd0);
    chk("rst_d_den", {31'd0, mem_d_denied}, 32'd0);
    chk("rst_d_cor", {31'd0, mem_d_corrupt}, 32'd0);
    chk("rst_d_data", mem_d_data, 32'd0);
    @(posedge cpu_clk_i);
    #1;
    cpu_rst_ni = 1'b1;
    @(negedge cpu_clk_i);
    chk("idle_a_ready", {31'd0, mem_a_ready}, 32'd1);
    @(posedge cpu_clk_i);
    #1;

    put_req(3'd0, 4'd2, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 16'h0, 1'b0, 1);
    get_req(4'd2, 32'h10, 1'b0, 1, 2, 1'b0, 1);

    put_req(3'd1, 4'd2, 32'h10, 4'h3, 32'h00001234, 32'd0, 16'h0, 1'b0, 1);
    get_req(4'd2, 32'h10, 1'b0, 1, 2, 1'b0, 1);
    chk("partial_model", model[4], 32'hDEAD1234);

    put_req(3'd0, 4'd5, 32'h40, 4'hF, 32'd1, 32'd1, 16'h0, 1'b0, 8);
    get_req(4'd5, 32'h40, 1'b0, 8, 2, 1'b0, 8);
    get_req(4'd5, 32'h40, 1'b0, 8, -1, 1'b1, 8);

    put_req(3'd0, 4'd2, 32'h84, 4'hF, 32'h5555AAAA, 32'd0, 16'h0, 1'b0, 1);
    put_req(3'd0, 4'd4, 32'h80, 4'hF, 32'hA0, 32'd1, 16'h0002, 1'b0, 4);
    get_req(4'd4, 32'h80, 1'b0, 4, 2, 1'b0, 4);

    put_req(3'd2, 4'd2, 32'h10, 4'hF, 32'hFFFFFFFF, 32'd0, 16'h0, ERR, 1);
    get_req(4'd2, 32'h10, 1'b0, 1, 2, 1'b0, 1);

    get_req(4'd2, 32'h12, ERR, 1, 2, 1'b0, 1);
    get_req(4'd2, 32'(DEPTH * 4) + 32'h10, ERR, 1, 2, 1'b0, 1);

    get_req(4'd5, 32'h40, 1'b0, 8, 2, 1'b0, 3);
    sb.delete();
    cpu_rst_ni = 1'b0;
    @(negedge cpu_clk_i);
    chk("mid_rst_a_ready", {31'd0, mem_a_ready}, 32'd0);
    @(posedge cpu_clk_i);
    #1;
    @(negedge cpu_clk_i);
    chk("mid_rst_d_valid", {31'd0, mem_d_valid}, 32'd0);
    @(posedge cpu_clk_i);
    #1;
    cpu_rst_ni = 1'b1;
    @(negedge cpu_clk_i);
    chk("post_rst_a_ready", {31'd0, mem_a_ready}, 32'd1);
    @(posedge cpu_clk_i);
    #1;
    get_req(4'd5, 32'h40, 1'b0, 8, 2, 1'b0, 8);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
